generic_fifo_drain: RTL
=======================

# generic_fifo_drain

Read-side drain stage for `generic_fifo`. It issues `read` while the FIFO is non-empty and absorbs the FIFO's one-cycle registered read latency in a 2-entry output buffer. It presents the words on a valid/ready stream with start/end-of-packet flags every `PACKET_LENGTH` words. It sits directly downstream of any `generic_fifo` instance in the PE array and sustains one word per cycle with no bubbles.

## Interface
- `DATA_WIDTH`, 32, width of FIFO `read_data` and `out_data`.
- `PACKET_LENGTH`, 16, words per packet for flag generation; must be ≥1.
- `COUNT_WIDTH`, max(1, $clog2(`PACKET_LENGTH`)), width of the word-in-packet index.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_poweron`  in  1  synchronous, active-high reset.
- `clear`  in  1  synchronous flush, active-high; asserted together with the FIFO's `clear`.
- `fifo_empty`  in  1  FIFO `empty` (combinational in the FIFO).
- `fifo_read`  out  1  FIFO `read` strobe; combinational.
- `fifo_read_data`  in  `DATA_WIDTH`  FIFO `read_data`; valid the cycle after `fifo_read`.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  `DATA_WIDTH`  output word.
- `out_som`  out  1  first word of packet; qualified by `out_valid`.
- `out_eom`  out  1  last word of packet; qualified by `out_valid`.
- `word_count`  out  32  total accepted output words; exists only with `GENERIC_FIFO_DRAIN_WORD_COUNT_EN`.

## Operation
- State:
  - `occ` (0..2), buffered words.
  - `pend` (0/1), a read was issued last cycle.
  - `idx` (0..`PACKET_LENGTH`-1).
  - 2-entry buffer; head entry drives `out_data`.
- `pop = out_valid & out_ready`.
- `fifo_read = ~fifo_empty & ~clear & ~reset_poweron & (occ + pend - pop < 2)`.
- Invariant: `occ + pend ≤ 2` at all times.
- Cycle after `fifo_read`: `pend`=1, and `fifo_read_data` is written into the buffer tail.
- Same-cycle push and pop are legal: `occ` stays unchanged, the head advances, and the new word lands behind any remaining word.
- Ordering is strictly FIFO; no word is dropped or duplicated outside of clear/reset.
- `out_valid = (occ != 0)`.
- `out_som = out_valid & (idx == 0)`; `out_eom = out_valid & (idx == PACKET_LENGTH-1)`.
- On `pop`, `idx` increments; it wraps to 0 after `PACKET_LENGTH-1`.
- `PACKET_LENGTH`=1: `out_som` and `out_eom` both assert on every word.
- Stall rule: while `out_valid & ~out_ready`, `out_data`, `out_som` and `out_eom` hold stable.
- Clear/reset behaviour (`reset_poweron` has priority over `clear`):
  - `occ`, `pend`, `idx` → 0, and `word_count` → 0 when present.
  - Data returning from a read issued the cycle before clear/reset is discarded.
  - Clear/reset mid-packet restarts framing at `idx`=0.

## Timing
- Reset values:
  - `out_valid`=0, `out_som`=0, `out_eom`=0, `fifo_read`=0.
  - `out_data`=0; the buffer entries also reset to 0.
- FIFO non-empty at cycle N, buffer empty: `fifo_read`=1 at N, `out_valid`=1 at N+2. This two-cycle latency is the minimum.
- With `out_ready` held at 1 and the FIFO non-empty: `fifo_read`=1 and a pop occur every cycle (steady state `occ`=1, `pend`=1).
- `out_ready` deasserted for one cycle:
  - The in-flight word fills the second entry, so `occ`=2 and `fifo_read`=0.
  - Streaming resumes without a bubble once `out_ready` returns.
- Output path:
  - `out_data` is registered.
  - `out_valid`, `out_som` and `out_eom` are derived only from registers.
  - `out_ready` → `fifo_read` is a combinational path, which is intentional.

## Configuration
- `GENERIC_FIFO_DRAIN_WORD_COUNT_EN` defined:
  - Adds port `word_count`, a 32-bit counter incremented on each `pop`.
  - It wraps at 2^32 and is cleared by `reset_poweron` or `clear`.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared header `generic_fifo_drain.vh` (included alongside `common.vh`) holds:
  - Default `DATA_WIDTH`/`PACKET_LENGTH` defines.
  - Buffer depth constant 2.
  - Occupancy encodings.
- Sub-module `generic_fifo_drain_buffer`: 2-entry push/pop register buffer with `occ` output. The top level holds the read issue logic, `pend`, framing and the counter.

## Test plan
- Reset, then write 20 words 0..19 into the FIFO, `out_ready`=1:
  - First `out_valid` appears 2 cycles after the first `fifo_read`.
  - 20 consecutive cycles of `out_valid`, data 0..19.
  - `out_som` on words 0 and 16; `out_eom` on word 15 only.
- Same stream with `out_ready` toggling 1,0,1,0:
  - Output sequence is still 0..19 with no loss or duplication.
  - `occ` never exceeds 2.
  - `out_data` is stable during stalls.
- `out_ready`=0 with the FIFO holding 5 words:
  - Exactly 2 `fifo_read` pulses, then `fifo_read`=0.
  - FIFO `depth` is 3.
- Assert `clear` the cycle after a `fifo_read` with `idx`=7:
  - Next cycle `out_valid`=0.
  - The returning word is discarded.
  - The next word carries `out_som`=1.
- `PACKET_LENGTH`=1, 3 words: `out_som`=`out_eom`=1 on every word.
- With `GENERIC_FIFO_DRAIN_WORD_COUNT_EN`, 37 pops then `clear`: `word_count` reads 37, then 0 the cycle after `clear`.

Source files
------------

// File: rtl/generic_fifo_drain_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | generic_fifo_drain_pkg                                                     |
// | Shared defaults, buffer depth and occupancy encodings for the FIFO drain.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package generic_fifo_drain_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_PACKET_LENGTH = 16;
    localparam int BUF_DEPTH             = 2;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

    // Word-in-packet index width; never narrower than one bit.
    function automatic int count_width(input int packet_length);
        return (packet_length <= 2) ? 1 : $clog2(packet_length);
    endfunction

endpackage : generic_fifo_drain_pkg
`default_nettype wire

// File: rtl/generic_fifo_drain_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | generic_fifo_drain_if                                                      |
// | FIFO read port and output valid/ready stream of the drain stage.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface generic_fifo_drain_if
    import generic_fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                  fifo_empty;
    logic                  fifo_read;
    logic [DATA_WIDTH-1:0] fifo_read_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_som;
    logic                  out_eom;

    // Drain side: reads the FIFO and sources the stream.
    modport master (
        input  fifo_empty,
        input  fifo_read_data,
        input  out_ready,
        output fifo_read,
        output out_valid,
        output out_data,
        output out_som,
        output out_eom
    );

    // Environment side: the FIFO plus the downstream consumer.
    modport slave (
        output fifo_empty,
        output fifo_read_data,
        output out_ready,
        input  fifo_read,
        input  out_valid,
        input  out_data,
        input  out_som,
        input  out_eom
    );

endinterface : generic_fifo_drain_if
`default_nettype wire

// File: rtl/generic_fifo_drain_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | generic_fifo_drain_buffer                                                  |
// | Two-entry push/pop register buffer; the head entry is the output word.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module generic_fifo_drain_buffer
    import generic_fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_flush,
    input  wire logic                  i_push,
    input  wire logic [DATA_WIDTH-1:0] i_push_data,
    input  wire logic                  i_pop,
    output occ_t                       o_occ,
    output logic      [DATA_WIDTH-1:0] o_head
);

    occ_t                  occ_q;
    occ_t                  occ_d;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] head_d;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [DATA_WIDTH-1:0] tail_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (i_flush) begin
            occ_d  = OCC_EMPTY;
            head_d = '0;
            tail_d = '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (occ_q == OCC_EMPTY) begin
                        head_d = i_push_data;
                    end else begin
                        tail_d = i_push_data;
                    end
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    head_d = tail_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word goes behind any survivor.
                    if (occ_q == OCC_FULL) begin
                        head_d = tail_q;
                        tail_d = i_push_data;
                    end else begin
                        head_d = i_push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign o_occ  = occ_q;
    assign o_head = head_q;

endmodule : generic_fifo_drain_buffer
`default_nettype wire

// File: rtl/generic_fifo_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | generic_fifo_drain                                                         |
// | Drains a generic_fifo onto a framed valid/ready stream at one word/cycle.  |
// | Option: GENERIC_FIFO_DRAIN_WORD_COUNT_EN adds the word_count port.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module generic_fifo_drain
    import generic_fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int PACKET_LENGTH = DEFAULT_PACKET_LENGTH,
    parameter int COUNT_WIDTH   = count_width(PACKET_LENGTH)
) (
    input  wire logic            clk,
    input  wire logic            reset_poweron,
    input  wire logic            clear,
    generic_fifo_drain_if.master bus
`ifdef GENERIC_FIFO_DRAIN_WORD_COUNT_EN
    ,
    output logic [31:0]          word_count
`endif
);

    localparam logic [COUNT_WIDTH-1:0] IDX_LAST = COUNT_WIDTH'(PACKET_LENGTH - 1);

    occ_t                   w_occ;
    logic [DATA_WIDTH-1:0]  w_head;
    logic                   w_flush;
    logic                   w_pop;
    logic                   w_read;
    logic [2:0]             w_commit;

    logic                   pend_q;
    logic                   pend_d;
    logic [COUNT_WIDTH-1:0] idx_q;
    logic [COUNT_WIDTH-1:0] idx_d;

    assign w_flush  = reset_poweron | clear;
    assign w_pop    = bus.out_valid & bus.out_ready;
    assign w_commit = {1'b0, w_occ} + {2'b00, pend_q};

    // Committed slots (buffered + in flight) minus this cycle's pop must leave room.
    assign w_read   = ~bus.fifo_empty & ~w_flush
                    & (w_commit < (3'd2 + {2'b00, w_pop}));

    assign bus.fifo_read = w_read;

    // A returning word from a pre-flush read is dropped by the flush itself.
    generic_fifo_drain_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buffer (
        .clk         (clk),
        .rst         (reset_poweron),
        .i_flush     (clear),
        .i_push      (pend_q),
        .i_push_data (bus.fifo_read_data),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head      (w_head)
    );

    always_comb begin
        pend_d = w_read;
        idx_d  = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (w_pop) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            pend_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            pend_q <= pend_d;
            idx_q  <= idx_d;
        end
    end

    assign bus.out_valid = (w_occ != OCC_EMPTY);
    assign bus.out_data  = w_head;
    assign bus.out_som   = bus.out_valid & (idx_q == '0);
    assign bus.out_eom   = bus.out_valid & (idx_q == IDX_LAST);

`ifdef GENERIC_FIFO_DRAIN_WORD_COUNT_EN
    logic [31:0] word_count_q;
    logic [31:0] word_count_d;

    always_comb begin
        word_count_d = word_count_q;
        if (clear) begin
            word_count_d = '0;
        end else if (w_pop) begin
            word_count_d = word_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            word_count_q <= '0;
        end else begin
            word_count_q <= word_count_d;
        end
    end

    assign word_count = word_count_q;
`endif

endmodule : generic_fifo_drain
`default_nettype wire
